// File: rtl/donkey_key_decoder.sv
// -----------------------------------------------------------------------------
// donkey_key_decoder
//
// Input stage of donkey_movement. This block decodes PS/2 scan-code set-2
// bytes into held-key levels and a sticky start_game flag. It tracks the E0
// (extended) and F0 (break) prefixes. A prefix that waits too long for its
// follow-up byte is discarded. All outputs are registered.
//
// Parameters
//   TIMEOUT_CYCLES  maximum number of clk cycles from a prefix byte to its
//                   follow-up byte before the prefix is discarded
//   CNT_W           width of the timeout counter (2**CNT_W > TIMEOUT_CYCLES)
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous reset, active-low
//   key_data    in   [7:0] scan-code byte
//   key_valid   in   1-cycle strobe qualifying key_data
//   game_over   in   level; while high, clears all outputs and drops bytes
//   left        out  Left arrow held  (E0 6B)
//   right       out  Right arrow held (E0 74)
//   up          out  Up arrow held    (E0 75)
//   down        out  Down arrow held  (E0 72)
//   jump        out  Space held       (29)
//   start_game  out  sticky, set by an Enter make (5A)
// -----------------------------------------------------------------------------
module donkey_key_decoder #(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int CNT_W          = 21
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] key_data,
    input  logic       key_valid,
    input  logic       game_over,
    output logic       left,
    output logic       right,
    output logic       up,
    output logic       down,
    output logic       jump,
    output logic       start_game
);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    localparam logic [7:0] CODE_UP    = 8'h75;
    localparam logic [7:0] CODE_DOWN  = 8'h72;
    localparam logic [7:0] CODE_SPACE = 8'h29;
    localparam logic [7:0] CODE_ENTER = 8'h5A;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] timeout_cnt;
    logic             left_next;
    logic             right_next;
    logic             up_next;
    logic             down_next;
    logic             jump_next;
    logic             start_next;

    // Next-state and next-output decode.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        state_next = state;
        left_next  = left;
        right_next = right;
        up_next    = up;
        down_next  = down;
        jump_next  = jump;
        start_next = start_game;

        if (game_over) begin
            // game_over wins over any byte arriving on the same cycle.
            state_next = ST_IDLE;
            left_next  = 1'b0;
            right_next = 1'b0;
            up_next    = 1'b0;
            down_next  = 1'b0;
            jump_next  = 1'b0;
            start_next = 1'b0;
        end else if (key_valid) begin
            unique case (state)
                ST_IDLE: begin
                    case (key_data)
                        CODE_EXT:   state_next = ST_EXT;
                        CODE_BRK:   state_next = ST_BRK;
                        CODE_SPACE: jump_next  = 1'b1;
                        CODE_ENTER: start_next = 1'b1;
                        default:    ;  // repeats, BAT, ack, pause prefix
                    endcase
                end
                ST_EXT: begin
                    state_next = ST_IDLE;
                    case (key_data)
                        CODE_BRK:   state_next = ST_EXT_BRK;
                        CODE_EXT:   state_next = ST_EXT;
                        CODE_LEFT:  left_next  = 1'b1;
                        CODE_RIGHT: right_next = 1'b1;
                        CODE_UP:    up_next    = 1'b1;
                        CODE_DOWN:  down_next  = 1'b1;
                        default:    ;
                    endcase
                end
                ST_BRK: begin
                    // An Enter release lands in the default arm, so
                    // start_game stays sticky.
                    state_next = ST_IDLE;
                    case (key_data)
                        CODE_SPACE: jump_next  = 1'b0;
                        CODE_EXT:   state_next = ST_EXT;
                        CODE_BRK:   state_next = ST_BRK;
                        default:    ;
                    endcase
                end
                ST_EXT_BRK: begin
                    state_next = ST_IDLE;
                    case (key_data)
                        CODE_LEFT:  left_next  = 1'b0;
                        CODE_RIGHT: right_next = 1'b0;
                        CODE_UP:    up_next    = 1'b0;
                        CODE_DOWN:  down_next  = 1'b0;
                        CODE_EXT:   state_next = ST_EXT;
                        CODE_BRK:   state_next = ST_BRK;
                        default:    ;
                    endcase
                end
                default: state_next = ST_IDLE;
            endcase
        end else if (state != ST_IDLE && timeout_cnt == TIMEOUT_LAST) begin
            // A stale prefix is dropped without touching any level.
            state_next = ST_IDLE;
        end
    end

    // State, output and timeout registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so every
        // register samples values from before the edge, whatever the
        // statement order.
        if (!rst) begin
            state       <= ST_IDLE;
            timeout_cnt <= '0;
            left        <= 1'b0;
            right       <= 1'b0;
            up          <= 1'b0;
            down        <= 1'b0;
            jump        <= 1'b0;
            start_game  <= 1'b0;
        end else begin
            state      <= state_next;
            left       <= left_next;
            right      <= right_next;
            up         <= up_next;
            down       <= down_next;
            jump       <= jump_next;
            start_game <= start_next;

            // The counter restarts on every byte, so entering a prefix state
            // always starts the count at zero. It saturates at the timeout
            // value and does not wrap.
            if (game_over || key_valid || state == ST_IDLE) begin
                timeout_cnt <= '0;
            end else if (timeout_cnt != TIMEOUT_LAST) begin
                timeout_cnt <= timeout_cnt + CNT_W'(1);
            end
        end
    end

endmodule
